// File: rtl/pwm_ramp_ctrl.sv
// ============================================================================
// Module  : pwm_ramp_ctrl
// Brief   : Soft-start / fade sequencer writing top then a stepped compare
//           value into a single 16-bit PWM through its d/sel port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_ramp_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] top_cfg,
    input  logic [W-1:0] cmp_start,
    input  logic [W-1:0] cmp_end,
    input  logic [W-1:0] step,
    input  logic [W-1:0] hold,
    output logic [W-1:0] pwm_d,
    output logic [1:0]   pwm_sel,
    output logic [W-1:0] cur_cmp,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] c_SEL_NONE = 2'd0;
    localparam logic [1:0] c_SEL_CMP  = 2'd1;
    localparam logic [1:0] c_SEL_TOP  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_TOP = 3'd1,
        S_LOAD_CMP = 3'd2,
        S_WAIT     = 3'd3,
        S_STEP     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_top;
    logic [W-1:0] r_end;
    logic [W-1:0] r_step;
    logic [W-1:0] r_hold;
    logic [W-1:0] r_cur;
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cur_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_latch;

    logic [W-1:0] w_start_cl;
    logic [W-1:0] w_end_cl;
    logic [W:0]   w_sum;
    logic [W:0]   w_dif;
    logic [W-1:0] w_cur_step;

    // Both endpoints are clamped to the period so the ramp never exceeds top.
    assign w_start_cl = (cmp_start < top_cfg) ? cmp_start : top_cfg;
    assign w_end_cl   = (cmp_end   < top_cfg) ? cmp_end   : top_cfg;

    // One extra bit lets a large step overflow or borrow without wrapping.
    assign w_sum = {1'b0, r_cur} + {1'b0, r_step};
    assign w_dif = {1'b0, r_cur} - {1'b0, r_step};

    always_comb begin
        w_cur_step = r_end;
        if (r_step == '0) begin
            w_cur_step = r_end;
        end else if (r_end >= r_cur) begin
            w_cur_step = (w_sum > {1'b0, r_end}) ? r_end : w_sum[W-1:0];
        end else begin
            w_cur_step = (w_dif[W] || (w_dif < {1'b0, r_end})) ? r_end : w_dif[W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_latch     = 1'b1;
                    w_cur_nxt   = w_start_cl;
                    w_state_nxt = S_LOAD_TOP;
                end
            end
            S_LOAD_TOP: w_state_nxt = S_LOAD_CMP;
            S_LOAD_CMP: begin
                if (r_cur == r_end) begin
                    w_state_nxt = S_DONE;
                end else if (r_hold == '0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_cnt_nxt   = r_hold - 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_STEP: begin
                w_cur_nxt   = w_cur_step;
                w_state_nxt = S_LOAD_CMP;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_top   <= '0;
            r_end   <= '0;
            r_step  <= '0;
            r_hold  <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_top  <= top_cfg;
                r_end  <= w_end_cl;
                r_step <= step;
                r_hold <= hold;
            end
        end
    end

    // Outputs are registered from the next state so each write lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_d   <= '0;
            pwm_sel <= c_SEL_NONE;
            cur_cmp <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            done <= (w_state_nxt == S_DONE);
            case (w_state_nxt)
                S_LOAD_TOP: begin
                    pwm_sel <= c_SEL_TOP;
                    pwm_d   <= top_cfg;
                end
                S_LOAD_CMP: begin
                    pwm_sel <= c_SEL_CMP;
                    pwm_d   <= w_cur_nxt;
                    cur_cmp <= w_cur_nxt;
                end
                default: begin
                    pwm_sel <= c_SEL_NONE;
                    pwm_d   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
// ============================================================================
// Module  : tb_pwm_ramp_ctrl
// Brief   : Scoreboard bench for pwm_ramp_ctrl with a list-based ramp model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] top_cfg = '0;
    logic [W-1:0] cmp_start = '0;
    logic [W-1:0] cmp_end = '0;
    logic [W-1:0] step = '0;
    logic [W-1:0] hold = '0;
    logic [W-1:0] pwm_d;
    logic [1:0]   pwm_sel;
    logic [W-1:0] cur_cmp;
    logic         busy;
    logic         done;

    pwm_ramp_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .top_cfg   (top_cfg),
        .cmp_start (cmp_start),
        .cmp_end   (cmp_end),
        .step      (step),
        .hold      (hold),
        .pwm_d     (pwm_d),
        .pwm_sel   (pwm_sel),
        .cur_cmp   (cur_cmp),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sel 1 = cmp write, 2 = top write, 3 = done pulse
    typedef struct {
        int c;
        int sel;
        int d;
    } ev_t;

    ev_t q[$];
    ev_t mon_ev;
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  model_cur = 0;
    int  acc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int c, input int s, input int d);
        ev_t e;
        e.c = c;
        e.sel = s;
        e.d = d;
        q.push_back(e);
    endtask

    // Expected transaction list for one ramp, from the ramp rules directly.
    task automatic issue(input int t, input int cs, input int ce, input int st, input int hd);
        int cur;
        int e;
        int tc;
        bit fin;
        top_cfg = t[W-1:0];
        cmp_start = cs[W-1:0];
        cmp_end = ce[W-1:0];
        step = st[W-1:0];
        hold = hd[W-1:0];
        start = 1'b1;
        acc = cyc;
        cur = (cs < t) ? cs : t;
        e = (ce < t) ? ce : t;
        push_ev(acc + 1, 2, t);
        tc = acc + 2;
        fin = 1'b0;
        while (!fin) begin
            push_ev(tc, 1, cur);
            if (cur == e) begin
                fin = 1'b1;
            end else begin
                if (st == 0) cur = e;
                else if (e >= cur) cur = (cur + st > e) ? e : cur + st;
                else cur = (cur - st < e) ? e : cur - st;
                tc += hd + 2;
            end
        end
        push_ev(tc + 1, 3, 0);
        busy_lo = acc + 1;
        busy_hi = tc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        top_cfg = W'($urandom);
        cmp_start = W'($urandom);
        cmp_end = W'($urandom);
        step = W'($urandom);
        hold = W'($urandom);
    endtask

    task automatic do_abort();
        ev_t keep[$];
        abort = 1'b1;
        foreach (q[i]) if (q[i].c <= cyc) keep.push_back(q[i]);
        q = keep;
        if (busy_hi > cyc) busy_hi = cyc;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        wait_cyc(busy_hi + 2);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected stream whenever the DUT shows a write or done.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            chk("missed_event", 1'b0, cyc, q[0].c);
            void'(q.pop_front());
        end
        if (pwm_sel != 2'd0) begin
            if (q.size() == 0 || q[0].sel == 3) begin
                chk("unexpected_write", 1'b0, pwm_sel, 0);
            end else begin
                mon_ev = q.pop_front();
                chk("write_sel", pwm_sel == mon_ev.sel[1:0], pwm_sel, mon_ev.sel);
                chk("write_data", pwm_d == mon_ev.d[W-1:0], pwm_d, mon_ev.d);
                chk("write_cycle", cyc == mon_ev.c, cyc, mon_ev.c);
                if (mon_ev.sel == 1) model_cur = mon_ev.d;
            end
        end
        if (done) begin
            if (q.size() == 0 || q[0].sel != 3) begin
                chk("unexpected_done", 1'b0, done, 0);
            end else begin
                mon_ev = q.pop_front();
                chk("done_cycle", cyc == mon_ev.c, cyc, mon_ev.c);
            end
        end
        chk("busy", busy == (cyc >= busy_lo && cyc <= busy_hi), busy,
            (cyc >= busy_lo && cyc <= busy_hi));
        chk("cur_cmp", cur_cmp == model_cur[W-1:0], cur_cmp, model_cur);
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, cs, ce, st, hd, ab;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm_d", pwm_d == 0, pwm_d, 0);
        chk("rst_pwm_sel", pwm_sel == 0, pwm_sel, 0);
        chk("rst_cur_cmp", cur_cmp == 0, cur_cmp, 0);
        chk("rst_busy", busy == 0, busy, 0);
        chk("rst_done", done == 0, done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(100, 10, 40, 10, 3);
        wait_idle();
        issue(100, 50, 5, 20, 0);
        wait_idle();
        issue(100, 150, 200, 0, 2);
        wait_idle();
        issue(65535, 65000, 65535, 60000, 1);
        wait_idle();
        issue(65535, 100, 0, 60000, 0);
        wait_idle();

        // Abort in WAIT, then a fresh accept three cycles later.
        issue(100, 10, 40, 10, 3);
        ab = acc;
        wait_cyc(ab + 9);
        do_abort();
        wait_cyc(ab + 12);
        issue(100, 40, 10, 15, 1);
        wait_idle();

        // Start while busy must be ignored.
        issue(100, 10, 40, 10, 3);
        wait_cyc(acc + 5);
        top_cfg = 500; cmp_start = 1; cmp_end = 2; step = 1; hold = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Start together with abort in IDLE is not accepted.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // Asynchronous reset while waiting.
        issue(100, 10, 40, 10, 3);
        wait_cyc(acc + 4);
        #2;
        rst = 1'b1;
        q.delete();
        busy_hi = cyc - 1;
        model_cur = 0;
        #1;
        chk("arst_pwm_d", pwm_d == 0, pwm_d, 0);
        chk("arst_pwm_sel", pwm_sel == 0, pwm_sel, 0);
        chk("arst_cur_cmp", cur_cmp == 0, cur_cmp, 0);
        chk("arst_busy", busy == 0, busy, 0);
        chk("arst_done", done == 0, done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_sel", pwm_sel == 0, pwm_sel, 0);
        chk("post_rst_busy", busy == 0, busy, 0);

        for (int k = 0; k < 25; k++) begin
            t = $urandom_range(1, 2000);
            cs = $urandom_range(0, 2500);
            ce = $urandom_range(0, 2500);
            st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(25, 400);
            hd = $urandom_range(0, 5);
            issue(t, cs, ce, st, hd);
            if ($urandom_range(0, 3) == 0) begin
                ab = $urandom_range(acc + 1, busy_hi);
                wait_cyc(ab);
                do_abort();
            end
            wait_idle();
        end

        chk("queue_empty", q.size() == 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
